control_ciclos: RTL and testbench

- Cycle scheduler that sequences the shared on/off actuator (encender) from two user buttons and the actuator's finished handshake.
- Button a arms, starts, cancels or aborts. Pulses on b program how many run cycles to execute.
- The block then runs the actuator that many times with a fixed gap between runs, then reports completion.
- Sits between the debounced button inputs and the actuator; a timeout watchdog flags an actuator that never completes.

---
 rtl/control_ciclos.sv | 156 +++++++++++++++
 tb/tb_control_ciclos.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/control_ciclos.sv
// Cycle scheduler: arms with button a, counts run requests on b, then runs the
// actuator (encender) that many times with a fixed low gap between runs.
module control_ciclos #(
  parameter int unsigned MAX_CYCLES = 7,
  parameter int unsigned CNT_W      = 3,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             finished,
  output logic             encender,
  output logic             listo,
  output logic             error,
  output logic [2:0]       estado,
  output logic [CNT_W-1:0] ciclos_pend
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARMED = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] GAP   = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [2:0] ERROR = 3'd5;

  logic [2:0]       state, state_nxt;
  logic             a_r, b_r, f_r;
  logic [CNT_W-1:0] count_req, count_nxt;
  logic [CNT_W-1:0] done_cnt, done_nxt;
  logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic             a_rise, b_rise, f_rise;
  logic [CNT_W-1:0] done_inc;
  logic             enc_nxt, listo_nxt, error_nxt;
  logic [CNT_W-1:0] pend_nxt;

  assign a_rise   = a & ~a_r;
  assign b_rise   = b & ~b_r;
  assign f_rise   = finished & ~f_r;
  assign done_inc = CNT_W'(done_cnt + 1'b1);
  assign estado   = state;

  // State, counters, edge history and registered Moore outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_r         <= 1'b0;
      b_r         <= 1'b0;
      f_r         <= 1'b0;
      count_req   <= '0;
      done_cnt    <= '0;
      tmo_cnt     <= '0;
      gap_cnt     <= '0;
      encender    <= 1'b0;
      listo       <= 1'b0;
      error       <= 1'b0;
      ciclos_pend <= '0;
    end else begin
      state       <= state_nxt;
      a_r         <= a;
      b_r         <= b;
      f_r         <= finished;
      count_req   <= count_nxt;
      done_cnt    <= done_nxt;
      tmo_cnt     <= tmo_nxt;
      gap_cnt     <= gap_nxt;
      encender    <= enc_nxt;
      listo       <= listo_nxt;
      error       <= error_nxt;
      ciclos_pend <= pend_nxt;
    end
  end

  // Next-state and counter update; abort on a outranks finished and timeout
  always_comb begin
    state_nxt = state;
    count_nxt = count_req;
    done_nxt  = done_cnt;
    tmo_nxt   = tmo_cnt;
    gap_nxt   = gap_cnt;
    case (state)
      IDLE: begin
        if (a_rise) begin
          state_nxt = ARMED;
          count_nxt = '0;
          done_nxt  = '0;
        end
      end
      ARMED: begin
        if (a_rise) begin
          if (count_req != '0) begin
            state_nxt = RUN;
            tmo_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (b_rise && (count_req < CNT_W'(MAX_CYCLES))) begin
          count_nxt = CNT_W'(count_req + 1'b1);
        end
      end
      RUN: begin
        if (a_rise) begin
          state_nxt = IDLE;
        end else if (f_rise) begin
          done_nxt = done_inc;
          if (done_inc == count_req) begin
            state_nxt = DONE;
          end else begin
            state_nxt = GAP;
            gap_nxt   = '0;
          end
        end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
          state_nxt = ERROR;
        end else begin
          tmo_nxt = TMO_W'(tmo_cnt + 1'b1);
        end
      end
      GAP: begin
        if (a_rise) begin
          state_nxt = IDLE;
        end else if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          state_nxt = RUN;
          tmo_nxt   = '0;
        end else begin
          gap_nxt = GAP_W'(gap_cnt + 1'b1);
        end
      end
      DONE: begin
        if (a_rise) state_nxt = IDLE;
      end
      ERROR: begin
        state_nxt = ERROR;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so outputs register alongside it
  always_comb begin
    enc_nxt   = (state_nxt == RUN);
    listo_nxt = (state_nxt == DONE);
    error_nxt = (state_nxt == ERROR);
    pend_nxt  = '0;
    if ((state_nxt == ARMED) || (state_nxt == RUN) || (state_nxt == GAP)) begin
      pend_nxt = CNT_W'(count_nxt - done_nxt);
    end
  end

endmodule

// File: tb/tb_control_ciclos.sv
// Directed bench for control_ciclos with hand-computed expectations.
module tb_control_ciclos;

  logic       clk = 1'b0;
  logic       rst;
  logic       a;
  logic       b;
  logic       finished;
  logic       encender;
  logic       listo;
  logic       error;
  logic [2:0] estado;
  logic [2:0] ciclos_pend;

  int checks = 0;
  int errors = 0;
  int lowcnt;

  control_ciclos dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .b           (b),
    .finished    (finished),
    .encender    (encender),
    .listo       (listo),
    .error       (error),
    .estado      (estado),
    .ciclos_pend (ciclos_pend)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n clocks, landing 1 time unit after the last rising edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_a();
    a = 1'b1; step(1);
    a = 1'b0; step(1);
  endtask

  task automatic press_b();
    b = 1'b1; step(1);
    b = 1'b0; step(1);
  endtask

  // Count cycles encender stays low after a GAP entry already observed
  task automatic measure_gap(output int low);
    low = 1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (encender) break;
      low++;
    end
  endtask

  initial begin
    rst = 1'b1; a = 1'b0; b = 1'b0; finished = 1'b0;
    step(2);
    rst = 1'b0;
    chk("rst_estado", 32'(estado), 0);
    chk("rst_enc", 32'(encender), 0);
    chk("rst_listo", 32'(listo), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_pend", 32'(ciclos_pend), 0);

    // Program three runs and start
    a = 1'b1; step(1);
    chk("arm_estado", 32'(estado), 1);
    a = 1'b0; step(1);
    repeat (3) press_b();
    chk("prog_pend", 32'(ciclos_pend), 3);
    chk("prog_enc", 32'(encender), 0);
    a = 1'b1; step(1);
    chk("start_estado", 32'(estado), 2);
    chk("start_enc", 32'(encender), 1);
    chk("start_pend", 32'(ciclos_pend), 3);
    a = 1'b0; step(1);

    // Three completions with gaps in between
    finished = 1'b1; step(1);
    chk("run1_estado", 32'(estado), 3);
    chk("run1_pend", 32'(ciclos_pend), 2);
    finished = 1'b0;
    measure_gap(lowcnt);
    chk("gap1_len", 32'(lowcnt), 4);
    chk("gap1_estado", 32'(estado), 2);
    finished = 1'b1; step(1);
    chk("run2_pend", 32'(ciclos_pend), 1);
    finished = 1'b0;
    measure_gap(lowcnt);
    chk("gap2_len", 32'(lowcnt), 4);
    finished = 1'b1; step(1);
    chk("done_estado", 32'(estado), 4);
    chk("done_listo", 32'(listo), 1);
    chk("done_pend", 32'(ciclos_pend), 0);
    chk("done_enc", 32'(encender), 0);
    finished = 1'b0; step(1);
    b = 1'b1; step(1); b = 1'b0; step(1);
    chk("done_b_ignored", 32'(estado), 4);
    press_a();
    chk("done_exit_estado", 32'(estado), 0);
    chk("done_exit_listo", 32'(listo), 0);

    // Arm then cancel with zero count
    a = 1'b1; step(1);
    chk("cancel_arm", 32'(estado), 1);
    a = 1'b0; step(1);
    a = 1'b1; step(1);
    chk("cancel_estado", 32'(estado), 0);
    chk("cancel_enc", 32'(encender), 0);
    a = 1'b0; step(1);

    // Saturation, simultaneous a/b, then timeout
    press_a();
    repeat (9) press_b();
    chk("sat_pend", 32'(ciclos_pend), 7);
    a = 1'b1; b = 1'b1; step(1);
    chk("ab_estado", 32'(estado), 2);
    chk("ab_pend", 32'(ciclos_pend), 7);
    a = 1'b0; b = 1'b0; step(1);
    step(248);
    chk("tmo_still_run", 32'(estado), 2);
    step(10);
    chk("tmo_estado", 32'(estado), 5);
    chk("tmo_error", 32'(error), 1);
    chk("tmo_enc", 32'(encender), 0);
    press_a();
    chk("err_sticky", 32'(estado), 5);
    rst = 1'b1; step(1); rst = 1'b0;
    chk("err_rst_estado", 32'(estado), 0);
    chk("err_rst_error", 32'(error), 0);

    // Abort coinciding with a finished rise
    press_a();
    press_b(); press_b();
    press_a();
    chk("abort_pre", 32'(estado), 2);
    a = 1'b1; finished = 1'b1; step(1);
    chk("abort_estado", 32'(estado), 0);
    chk("abort_pend", 32'(ciclos_pend), 0);
    chk("abort_enc", 32'(encender), 0);
    a = 1'b0; finished = 1'b0; step(1);
    a = 1'b1; step(1);
    chk("rearm_pend", 32'(ciclos_pend), 0);
    a = 1'b0; step(1);

    // finished held across a gap is not a completion; reset while in GAP
    repeat (3) press_b();
    press_a();
    finished = 1'b1; step(1);
    chk("hold_gap_pend", 32'(ciclos_pend), 2);
    step(4);
    chk("hold_rerun", 32'(estado), 2);
    step(3);
    chk("hold_no_count", 32'(ciclos_pend), 2);
    chk("hold_still_run", 32'(estado), 2);
    finished = 1'b0; step(1);
    finished = 1'b1; step(1);
    chk("hold_second", 32'(ciclos_pend), 1);
    finished = 1'b0; step(1);
    chk("gap_before_rst", 32'(estado), 3);
    rst = 1'b1; step(1);
    chk("gaprst_estado", 32'(estado), 0);
    chk("gaprst_pend", 32'(ciclos_pend), 0);
    chk("gaprst_enc", 32'(encender), 0);
    chk("gaprst_listo", 32'(listo), 0);
    chk("gaprst_error", 32'(error), 0);
    rst = 1'b0; step(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
